// File: rtl/fpu_pkg.sv
// fpu_pkg
// Shared definitions for the FPU operation sequencer: controller state
// encoding, the 2-bit op-select encoding seen by the FPU core, and the
// default operand width.
package fpu_pkg;

    localparam int FPU_WIDTH = 32;

    // Op select as carried on {select1, select0} and driven on fpu_op.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_EXEC,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } seq_state_t;

endpackage

// File: rtl/ser2par.sv
// ser2par
// Dual-lane serial-to-parallel converter with a shared bit counter.
// Both lanes shift MSB-first into the LSB end, so after WIDTH shifts the
// first bit received sits in bit WIDTH-1.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   clr            zero both lanes and the counter
//   shift_en       shift one bit into each lane, count it
//   a_bit, b_bit   serial inputs for lane A / lane B
//   a_q, b_q       parallel lane contents
//   cnt            bits shifted since clear, saturating at WIDTH+1
module ser2par #(
    parameter int WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          shift_en,
    input  logic                          a_bit,
    input  logic                          b_bit,
    output logic [WIDTH-1:0]              a_q,
    output logic [WIDTH-1:0]              b_q,
    output logic [$clog2(WIDTH+2)-1:0]    cnt
);

    localparam int CW = $clog2(WIDTH + 2);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            a_q <= '0;
            b_q <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            a_q <= {a_q[WIDTH-2:0], a_bit};
            b_q <= {b_q[WIDTH-2:0], b_bit};
            // Saturate one past WIDTH so an over-long burst can never wrap
            // back around to a count that looks correct.
            if (cnt != CW'(WIDTH + 1))
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer
// Runs one arithmetic transaction: requests an operand burst, deserializes
// the two bit-serial operands and the op select, acknowledges the burst,
// launches the FPU, waits for completion and holds the result for the host.
//
// Optional feature: define FPU_SEQ_TIMEOUT_EN to enable a watchdog that
// aborts to ERR when SHIFT waits TIMEOUT cycles for ok, or WAIT waits
// TIMEOUT cycles for fpu_done. Without it both states wait indefinitely.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   go                       host transaction request (IDLE only)
//   dataready, stop          burst request / burst acknowledge pulses
//   num1_bit, num2_bit       serial operands A / B, MSB first
//   select0, select1         op select, op = {select1, select0}
//   ok                       burst complete from operand memory
//   fpu_a, fpu_b, fpu_op     latched operands and op to the FPU
//   fpu_start                one-cycle launch pulse
//   fpu_done, fpu_result     FPU completion strobe and its result
//   result, result_valid     captured result, valid until next go
//   busy                     high in every state except IDLE
//   err                      sticky bad-length / timeout flag
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int WIDTH   = FPU_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    output logic             dataready,
    output logic             stop,
    input  logic             num1_bit,
    input  logic             num2_bit,
    input  logic             select0,
    input  logic             select1,
    input  logic             ok,
    output logic [WIDTH-1:0] fpu_a,
    output logic [WIDTH-1:0] fpu_b,
    output logic [1:0]       fpu_op,
    output logic             fpu_start,
    input  logic             fpu_done,
    input  logic [WIDTH-1:0] fpu_result,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 2);

    if (WIDTH < 2) begin : g_bad_width
        $error("fpu_op_sequencer: WIDTH must be at least 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("fpu_op_sequencer: TIMEOUT must be at least 2");
    end

    seq_state_t       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    bit_cnt;
    logic             sp_clr;
    logic             sp_shift;

    // Counter is cleared when a transaction is accepted, so a stale count
    // from an aborted burst never leaks into the next one.
    assign sp_clr   = (state == ST_IDLE) && go;
    assign sp_shift = (state == ST_SHIFT) && !ok;

    ser2par #(.WIDTH(WIDTH)) u_ser2par (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sp_clr),
        .shift_en (sp_shift),
        .a_bit    (num1_bit),
        .b_bit    (num2_bit),
        .a_q      (sh_a),
        .b_q      (sh_b),
        .cnt      (bit_cnt)
    );

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmr;
    logic          tmr_expired;

    // tmr holds N during the N-th cycle spent in SHIFT or WAIT. Leaving at
    // TIMEOUT-1 makes err visible exactly TIMEOUT cycles after the start
    // pulse when the FPU never answers.
    always_ff @(posedge clk) begin
        if (!rst_n)
            tmr <= '0;
        else if (state == ST_REQ || state == ST_EXEC)
            tmr <= TW'(1);
        else if ((state == ST_SHIFT || state == ST_WAIT) && tmr != '1)
            tmr <= tmr + 1'b1;
    end

    assign tmr_expired = (tmr == TW'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dataready    <= 1'b0;
            stop         <= 1'b0;
            fpu_start    <= 1'b0;
            fpu_a        <= '0;
            fpu_b        <= '0;
            fpu_op       <= 2'b00;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            // Handshake pulses are single-cycle by construction.
            dataready <= 1'b0;
            stop      <= 1'b0;
            fpu_start <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state        <= ST_REQ;
                        dataready    <= 1'b1;
                        busy         <= 1'b1;
                        err          <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end

                ST_REQ: state <= ST_SHIFT;

                ST_SHIFT: begin
                    if (ok) begin
                        fpu_op <= {select1, select0};
                        stop   <= 1'b1;
                        if (bit_cnt == CW'(WIDTH)) begin
                            state <= ST_ACK;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
`ifdef FPU_SEQ_TIMEOUT_EN
                    else if (tmr_expired) begin
                        state <= ST_ERR;
                        err   <= 1'b1;
                        stop  <= 1'b1;
                    end
`endif
                end

                ST_ACK: begin
                    fpu_a     <= sh_a;
                    fpu_b     <= sh_b;
                    fpu_start <= 1'b1;
                    state     <= ST_EXEC;
                end

                ST_EXEC: state <= ST_WAIT;

                ST_WAIT: begin
                    if (fpu_done) begin
                        result       <= fpu_result;
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end
`ifdef FPU_SEQ_TIMEOUT_EN
                    else if (tmr_expired) begin
                        state <= ST_ERR;
                        err   <= 1'b1;
                        stop  <= 1'b1;
                    end
`endif
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                ST_ERR: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
